// File: rtl/vector_mul_stream_out_if.sv
// Operand-in / product-out stream bundle for vector_mul_stream_out.
// master = operand source and product consumer, slave = the multiplier block.
`default_nettype none

interface vector_mul_stream_out_if #(
  parameter int VEC_LEN = 5,
  parameter int DATA_W  = 32
);
  localparam int IDX_W = $clog2(VEC_LEN);

  logic                      in_valid;
  logic                      in_ready;
  logic [VEC_LEN*DATA_W-1:0] in_a;
  logic [VEC_LEN*DATA_W-1:0] in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_last;
  logic                      out_sat;
  logic                      busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, out_sat, busy
  );
endinterface

`default_nettype wire

// File: rtl/vector_mul_stream_out.sv
// Element-wise saturating fixed-point vector multiply, one shared multiplier, serial output.
// First product 1 cycle after accept, then one per cycle; stalls hold outputs, no input taken while streaming.
`default_nettype none

module vector_mul_stream_out #(
  parameter int VEC_LEN   = 5,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_mul_stream_out_if.slave  bus
);
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int PW    = 2 * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]               state;
  logic signed [DATA_W-1:0] a_mem [VEC_LEN];
  logic signed [DATA_W-1:0] b_mem [VEC_LEN];

  logic                     valid_q;
  logic [DATA_W-1:0]        data_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     sat_q;
  logic                     last_q;

  logic [IDX_W-1:0]         nidx;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic signed [PW-1:0]     ext_a;
  logic signed [PW-1:0]     ext_b;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     shifted;
  logic [PW-DATA_W:0]       hi_bits;
  logic                     ovf;
  logic [DATA_W-1:0]        res_data;

  // In IDLE the multiplier sees element 0 straight off the input bus so the
  // first product lands in the same edge that latches the operands.
  always_comb begin
    nidx = '0;
    if (state == RUN && idx_q != LAST_IDX) begin
      nidx = idx_q + IDX_W'(1);
    end
    op_a = a_mem[nidx];
    op_b = b_mem[nidx];
    if (state == IDLE) begin
      op_a = bus.in_a[DATA_W-1:0];
      op_b = bus.in_b[DATA_W-1:0];
    end
  end

  assign ext_a   = {{DATA_W{op_a[DATA_W-1]}}, op_a};
  assign ext_b   = {{DATA_W{op_b[DATA_W-1]}}, op_b};
  assign prod    = ext_a * ext_b;
  assign shifted = prod >>> FRAC_BITS;

  // Result fits only if every bit from the output sign bit upward agrees.
  assign hi_bits  = shifted[PW-1:DATA_W-1];
  assign ovf      = !((&hi_bits) || (~|hi_bits));
  assign res_data = !ovf ? shifted[DATA_W-1:0] :
                    shifted[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                    {1'b0, {(DATA_W-1){1'b1}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < VEC_LEN; i++) begin
              a_mem[i] <= bus.in_a[i*DATA_W +: DATA_W];
              b_mem[i] <= bus.in_b[i*DATA_W +: DATA_W];
            end
            data_q  <= res_data;
            sat_q   <= ovf;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (bus.out_ready) begin
            if (idx_q == LAST_IDX) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= nidx;
              data_q <= res_data;
              sat_q  <= ovf;
              last_q <= (nidx == LAST_IDX);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_sat   = sat_q;
  assign bus.out_last  = last_q;
endmodule

`default_nettype wire

// File: tb/tb_vector_mul_stream_out.sv
// Bench for vector_mul_stream_out: queue-based product model checked every cycle,
// plus literal expectations on the captured output beats of each directed vector.
module tb_vector_mul_stream_out;
  localparam int N = 5;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_mul_stream_out_if #(.VEC_LEN(N), .DATA_W(W)) bus ();

  vector_mul_stream_out #(.VEC_LEN(N), .DATA_W(W), .FRAC_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sat;
    logic [2:0]  idx;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    acc_cyc[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_idx;
  logic        prev_sat;
  logic        prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Fixed-point product from first principles: 64-bit signed multiply, floor shift, clip.
  function automatic logic [32:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 16;
    if (p > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (p < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    else                           return {1'b0, p[31:0]};
  endfunction

  function automatic logic [159:0] pk(input logic [31:0] e0, e1, e2, e3, e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  // Compare process: model says a vector is in flight iff beats are queued.
  always @(negedge clk) begin
    logic        idle_exp;
    logic [32:0] r;
    if (rst) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_idx", bus.out_idx, 0);
      check("rst_out_sat", bus.out_sat, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_in_ready", bus.in_ready, 1);
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      idle_exp = (exp_q.size() == 0);
      check("in_ready", bus.in_ready, idle_exp);
      check("busy", bus.busy, !idle_exp);
      check("out_valid", bus.out_valid, !idle_exp);
      if (!idle_exp) begin
        check("out_data", bus.out_data, exp_q[0].data);
        check("out_idx", bus.out_idx, exp_q[0].idx);
        check("out_sat", bus.out_sat, exp_q[0].sat);
        check("out_last", bus.out_last, exp_q[0].last);
        if (prev_stall) begin
          check("stall_data", bus.out_data, prev_data);
          check("stall_idx", bus.out_idx, prev_idx);
          check("stall_sat", bus.out_sat, prev_sat);
          check("stall_last", bus.out_last, prev_last);
        end
      end else begin
        check("idle_out_last", bus.out_last, 0);
      end
      prev_stall = !idle_exp && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_idx   = bus.out_idx;
      prev_sat   = bus.out_sat;
      prev_last  = bus.out_last;
      if (!idle_exp && bus.out_ready) begin
        obs_q.push_back('{data: bus.out_data, sat: bus.out_sat, idx: bus.out_idx,
                          last: bus.out_last, cyc: cyc});
        void'(exp_q.pop_front());
      end else if (idle_exp && bus.in_valid) begin
        acc_cyc.push_back(cyc);
        for (int i = 0; i < N; i++) begin
          r = model_mul(bus.in_a[i*32 +: 32], bus.in_b[i*32 +: 32]);
          exp_q.push_back('{data: r[31:0], sat: r[32], idx: 3'(i), last: (i == N - 1), cyc: 0});
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [159:0] a, input logic [159:0] b);
    int base;
    logic to;
    base = acc_cyc.size();
    @(posedge clk);
    #1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_cyc.size() != base) begin
        to = 1'b0;
        break;
      end
    end
    check("accept_timeout", to, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.in_b = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    logic to;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_q.size() == 0) begin
        to = 1'b0;
        break;
      end
    end
    check("drain_timeout", to, 0);
  endtask

  task automatic chk_obs(input string tag, input int base, input logic [159:0] ed, input logic es);
    for (int i = 0; i < N; i++) begin
      check({tag, "_data"}, obs_q[base+i].data, ed[i*32 +: 32]);
      check({tag, "_sat"}, obs_q[base+i].sat, es);
      check({tag, "_idx"}, obs_q[base+i].idx, i);
      check({tag, "_last"}, obs_q[base+i].last, (i == N - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] a;
    logic [159:0] b;
    int stall;
    logic held;
    logic to;
    int base;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    #3;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1.0 * 2.5 on every element, consecutive beats.
    obs_q.delete();
    base = acc_cyc.size();
    start_vec({5{32'h0001_0000}}, {5{32'h0002_8000}});
    drain();
    check("t1_beats", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      chk_obs("t1", 0, {5{32'h0002_8000}}, 1'b0);
      check("t1_latency", obs_q[0].cyc, acc_cyc[base] + 1);
      for (int i = 1; i < N; i++) check("t1_consec", obs_q[i].cyc, obs_q[0].cyc + i);
    end

    // Signs and floor truncation.
    obs_q.delete();
    start_vec(pk(32'hFFFF_0000, 32'h1, 32'hFFFF_FFFF, 32'h0001_8000, 32'h0),
              pk(32'h0001_8000, 32'h1, 32'h1, 32'hFFFF_0000, 32'h7FFF_FFFF));
    drain();
    check("t2_beats", obs_q.size(), 5);
    if (obs_q.size() == 5)
      chk_obs("t2", 0, pk(32'hFFFE_8000, 32'h0, 32'hFFFF_FFFF, 32'hFFFE_8000, 32'h0), 1'b0);

    // Positive and negative saturation.
    obs_q.delete();
    start_vec({5{32'd1030792151}}, {5{32'd1653562408}});
    drain();
    start_vec({5{32'h7FFF_FFFF}}, {5{32'h8000_0000}});
    drain();
    check("t3_beats", obs_q.size(), 10);
    if (obs_q.size() == 10) begin
      chk_obs("t3_pos", 0, {5{32'h7FFF_FFFF}}, 1'b1);
      chk_obs("t3_neg", 5, {5{32'h8000_0000}}, 1'b1);
    end

    // Random backpressure with a 10-cycle stall at idx 2 and ignored in_valid pulses.
    obs_q.delete();
    start_vec(pk(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000), {5{32'h0002_0000}});
    held = 1'b0;
    stall = 0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        to = 1'b0;
        break;
      end
      if (stall > 0) begin
        stall--;
        bus.out_ready = 1'b0;
      end else if (!held && bus.out_valid && bus.out_idx == 3'd2) begin
        held = 1'b1;
        stall = 9;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      if (exp_q.size() > 1) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_a = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("t4_timeout", to, 0);
    check("t4_stall_hit", held, 1);
    check("t4_beats", obs_q.size(), 5);
    if (obs_q.size() == 5)
      chk_obs("t4", 0, pk(32'h2_0000, 32'h4_0000, 32'h6_0000, 32'h8_0000, 32'hA_0000), 1'b0);

    // Back-to-back with in_valid held high.
    obs_q.delete();
    base = acc_cyc.size();
    @(posedge clk);
    #1;
    bus.in_a = pk(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000);
    bus.in_b = {5{32'h0001_0000}};
    bus.in_valid = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_cyc.size() == base + 1) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_a = {5{32'hFFFF_8000}};
    bus.in_b = pk(32'h2_0000, 32'h4_0000, 32'h6_0000, 32'h8_0000, 32'hA_0000);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_cyc.size() == base + 2) break;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    check("t5_accept1_timeout", to, 0);
    check("t5_accepts", acc_cyc.size(), base + 2);
    check("t5_beats", obs_q.size(), 10);
    if (obs_q.size() == 10 && acc_cyc.size() == base + 2) begin
      chk_obs("t5_first", 0, pk(32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h5_0000), 1'b0);
      chk_obs("t5_second", 5, pk(32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFD_0000, 32'hFFFC_0000, 32'hFFFB_0000), 1'b0);
      check("t5_gap", acc_cyc[base + 1], obs_q[4].cyc + 1);
    end

    // Asynchronous reset after the idx-2 handshake.
    obs_q.delete();
    start_vec({5{32'h0004_0000}}, {5{32'h0001_0000}});
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (obs_q.size() >= 3) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    check("t6_wait_timeout", to, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_out_valid", bus.out_valid, 0);
    check("t6_async_in_ready", bus.in_ready, 1);
    check("t6_async_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("t6_partial_beats", obs_q.size(), 3);
    obs_q.delete();
    start_vec({5{32'h0003_0000}}, {5{32'h0001_0000}});
    drain();
    repeat (3) tick();
    check("t6_beats", obs_q.size(), 5);
    if (obs_q.size() == 5) chk_obs("t6", 0, {5{32'h0003_0000}}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vector_mul_stream_out.md
Name: vector_mul_stream_out

Overview:
- Companion to the parallel element-wise vector multiplier.
- Accepts one pair of signed 32-bit fixed-point vectors over a valid/ready handshake and computes the element-wise products with a single shared multiplier.
- Emits the products one element per transfer on a valid/ready output stream, carrying index and last flags.
- Sits between the vector operand source and any serial consumer, such as a result FIFO or a writeback.

Parameters:
- VEC_LEN, 5: number of elements per vector. Must be ≥ 2.
- DATA_W, 32: element width, signed two's complement.
- FRAC_BITS, 16: fractional bits of the fixed-point format. Applies to inputs and output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand vectors valid.
- in_ready  out  1  block can accept a vector pair.
- in_a  in  VEC_LEN*DATA_W  vector a, flattened; element i at bits [i*DATA_W +: DATA_W].
- in_b  in  VEC_LEN*DATA_W  vector b, same packing.
- out_valid  out  1  out_data holds a valid product.
- out_ready  in  1  consumer accepts the current product.
- out_data  out  DATA_W  saturated fixed-point product a[i]*b[i].
- out_idx  out  $clog2(VEC_LEN)  element index i of out_data.
- out_last  out  1  high when out_idx == VEC_LEN-1 and out_valid = 1.
- out_sat  out  1  out_data was clipped by saturation.
- busy  out  1  high in state RUN.

Behaviour:
- Reset (async assert, values hold while rst = 1):
  - state = IDLE; out_valid = 0; out_data = 0; out_idx = 0; out_sat = 0; out_last = 0.
  - Latched operands are discarded.
  - Reset mid-vector aborts the vector. No further products of it appear.
- in_ready = (state == IDLE), decoded from state only, with no combinational path from out_ready.
- States:
  - IDLE: in_ready = 1; out_valid = 0.
    - On in_valid & in_ready at edge k: latch in_a and in_b, compute the element-0 product into out_data, set out_idx = 0, out_valid = 1, go to RUN.
    - First output is visible after edge k (1-cycle latency).
  - RUN: in_ready = 0; busy = 1.
    - out_valid & !out_ready: out_data, out_idx, out_sat and out_last hold stable.
    - Handshake with out_idx < VEC_LEN-1: out_idx+1 and its product are registered at the same edge. This gives zero bubbles, one element per cycle under continuous out_ready.
    - Handshake with out_idx == VEC_LEN-1: go to IDLE and drop out_valid. The next vector can be accepted one cycle later.
- Throughput: VEC_LEN+1 cycles per vector at full out_ready.
- Changes on in_a or in_b during RUN have no effect.
- Arithmetic:
  - Full 2*DATA_W signed product, then arithmetic shift right by FRAC_BITS, i.e. truncation toward −∞.
  - If the result exceeds 2^(DATA_W-1)-1 → clip to 0x7FFFFFFF with out_sat = 1.
  - If the result is below −2^(DATA_W-1) → clip to 0x80000000 with out_sat = 1.
  - Otherwise out_sat = 0.
- out_sat and out_last are registered alongside out_data.

Test Plan:
- Reset, then a single vector: a = all 0x00010000 (1.0), b = all 0x00028000 (2.5), out_ready = 1.
  - Response: in_ready drops the cycle after acceptance.
  - Five beats of 0x00028000 on consecutive cycles with idx 0..4.
  - out_last on idx 4; in_ready = 1 one cycle after the last beat.
- Signs and truncation: a = {0xFFFF0000, 1, 0xFFFFFFFF, 0x00018000, 0}, b = {0x00018000, 1, 1, 0xFFFF0000, 0x7FFFFFFF}.
  - Response: out = {0xFFFE8000, 0, 0xFFFFFFFF, 0xFFFE8000, 0}, all with out_sat = 0.
- Saturation: all elements a = 1030792151 and b = 1653562408.
  - Response: every beat out_data = 0x7FFFFFFF with out_sat = 1.
  - Then a = 0x7FFFFFFF, b = 0x80000000 → 0x80000000 with out_sat = 1.
- Backpressure: out_ready toggled randomly, including held low for 10 cycles at idx 2.
  - Response: out_data, out_idx and out_sat stay stable while stalled.
  - No element is lost or duplicated; in_valid pulses during RUN are not accepted.
- Back-to-back: in_valid held high with two different vector pairs.
  - Response: the second pair is accepted exactly one cycle after the first pair's out_last handshake.
  - Ten beats in order.
- Reset mid-operation: assert rst asynchronously (between edges) after the idx-2 handshake.
  - Response: out_valid = 0 immediately; state IDLE.
  - After deassert, a new vector streams from idx 0 with no leftover beats.
